// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file for the decode stage.
// Reads are combinational with optional same-cycle write forwarding; an optional
// hardwired-zero entry always reads 0 and drops writes. Out-of-range addresses
// read 0 and never write. Asynchronous active-low clear of every entry.
module regfile_2r1w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_IDX = 31,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1
);

    // One extra bit so DEPTH == 2**AW is representable in the range compare.
    localparam logic [AW:0]   DepthA = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] ZeroA  = AW'(ZERO_IDX);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wsel;
    logic             wa_in_range;
    logic             wa_is_zero;
    logic             wr_ok;

    logic             ra0_in_range;
    logic             ra1_in_range;
    logic             ra0_is_zero;
    logic             ra1_is_zero;
    logic             ra0_hit;
    logic             ra1_hit;
    logic [WIDTH-1:0] stored0;
    logic [WIDTH-1:0] stored1;

    // Write qualification: full-width unsigned range check, zero entry excluded.
    always_comb begin
        wa_in_range = ({1'b0, wa} < DepthA);
        wa_is_zero  = ZERO_EN && (wa == ZeroA);
        wr_ok       = reset_n && we && wa_in_range && !wa_is_zero;
    end

    // One-hot write strobe per entry.
    always_comb begin
        wsel = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wsel[i] = wr_ok && (wa == AW'(i));
        end
    end

    // Storage entries; each loads only on its own strobe.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        // Asynchronous clear, clocked load.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem_q[g] <= '0;
            end else if (wsel[g]) begin
                mem_q[g] <= wd;
            end
        end
    end

    // Read-address classification for both ports.
    always_comb begin
        ra0_in_range = ({1'b0, ra0} < DepthA);
        ra1_in_range = ({1'b0, ra1} < DepthA);
        ra0_is_zero  = ZERO_EN && (ra0 == ZeroA);
        ra1_is_zero  = ZERO_EN && (ra1 == ZeroA);
        ra0_hit      = BYPASS && wr_ok && (wa == ra0);
        ra1_hit      = BYPASS && wr_ok && (wa == ra1);
    end

    // Stored-value selectors; unmatched addresses fall through to 0.
    always_comb begin
        stored0 = '0;
        stored1 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ra0 == AW'(i)) begin
                stored0 = mem_q[i];
            end
            if (ra1 == AW'(i)) begin
                stored1 = mem_q[i];
            end
        end
    end

    // Port 0 output priority: reset, range, zero entry, forward, storage.
    always_comb begin
        rd0 = '0;
        if (!reset_n || !ra0_in_range || ra0_is_zero) begin
            rd0 = '0;
        end else if (ra0_hit) begin
            rd0 = wd;
        end else begin
            rd0 = stored0;
        end
    end

    // Port 1 output priority, identical rules to port 0.
    always_comb begin
        rd1 = '0;
        if (!reset_n || !ra1_in_range || ra1_is_zero) begin
            rd1 = '0;
        end else if (ra1_hit) begin
            rd1 = wd;
        end else begin
            rd1 = stored1;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w: four parameter variants share one stimulus
// stream; expected reads are pushed when inputs are driven and a monitor pops
// and compares them shortly afterwards.
`timescale 1ns/1ps
module tb_regfile_2r1w;

    localparam int ND = 4;
    // Variants: default, no zero register, no bypass, shallow (DEPTH=20).
    localparam int CFG_DEPTH [ND] = '{32, 32, 32, 20};
    localparam bit CFG_ZEN   [ND] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam int CFG_ZIDX  [ND] = '{31, 31, 31, 19};
    localparam bit CFG_BYP   [ND] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        we      = 1'b0;
    logic [4:0]  wa      = '0;
    logic [63:0] wd      = '0;
    logic [4:0]  ra0     = '0;
    logic [4:0]  ra1     = '0;
    logic [63:0] rd0_w [ND];
    logic [63:0] rd1_w [ND];

    typedef struct {
        logic [2*ND-1:0][63:0] e;
        string                 name;
    } exp_t;

    exp_t        q[$];
    event        push_ev;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] model [ND][32];

    always #5 clk = ~clk;

    regfile_2r1w #(.WIDTH(64), .DEPTH(32), .AW(5), .ZERO_EN(1'b1), .ZERO_IDX(31),
                   .BYPASS(1'b1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_w[0]), .rd1(rd1_w[0]));
    regfile_2r1w #(.WIDTH(64), .DEPTH(32), .AW(5), .ZERO_EN(1'b0), .ZERO_IDX(31),
                   .BYPASS(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_w[1]), .rd1(rd1_w[1]));
    regfile_2r1w #(.WIDTH(64), .DEPTH(32), .AW(5), .ZERO_EN(1'b1), .ZERO_IDX(31),
                   .BYPASS(1'b0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_w[2]), .rd1(rd1_w[2]));
    regfile_2r1w #(.WIDTH(64), .DEPTH(20), .AW(5), .ZERO_EN(1'b1), .ZERO_IDX(19),
                   .BYPASS(1'b1)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_w[3]), .rd1(rd1_w[3]));

    // Reference: would the current write inputs update variant d at the next edge?
    function automatic bit accepts(input int d);
        return reset_n && we && (int'(wa) < CFG_DEPTH[d]) &&
               !(CFG_ZEN[d] && (int'(wa) == CFG_ZIDX[d]));
    endfunction

    // Reference read value for variant d at address ra under the current inputs.
    function automatic logic [63:0] mread(input int d, input int ra);
        if (!reset_n) return 64'h0;
        if (ra >= CFG_DEPTH[d]) return 64'h0;
        if (CFG_ZEN[d] && ra == CFG_ZIDX[d]) return 64'h0;
        if (CFG_BYP[d] && accepts(d) && int'(wa) == ra) return wd;
        return model[d][ra];
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < ND; d++) begin
            for (int r = 0; r < 32; r++) model[d][r] = 64'h0;
        end
    endfunction

    function automatic void model_commit();
        for (int d = 0; d < ND; d++) begin
            if (accepts(d)) model[d][int'(wa)] = wd;
        end
    endfunction

    task automatic push_exp(input string name);
        exp_t x;
        x.name = name;
        for (int d = 0; d < ND; d++) begin
            x.e[2*d]   = mread(d, int'(ra0));
            x.e[2*d+1] = mread(d, int'(ra1));
        end
        q.push_back(x);
        -> push_ev;
    endtask

    // One clock cycle: drive at the falling edge, expect, then commit at rising edge.
    task automatic cycle(input logic w, input logic [4:0] a, input logic [63:0] dat,
                         input logic [4:0] r0, input logic [4:0] r1, input string name);
        @(negedge clk);
        we  = w;
        wa  = a;
        wd  = dat;
        ra0 = r0;
        ra1 = r1;
        push_exp(name);
        @(posedge clk);
        model_commit();
    endtask

    // Reset pulse placed between edges; called right after a rising edge.
    task automatic reset_pulse(input string name);
        #1;
        reset_n = 1'b0;
        model_clear();
        push_exp(name);
        #3;
        reset_n = 1'b1;
    endtask

    // Monitor: sample 2 ns after each push and compare against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(push_ev);
            #2;
            while (q.size() > 0) begin
                x = q.pop_front();
                for (int d = 0; d < ND; d++) begin
                    n_checks++;
                    if (rd0_w[d] === x.e[2*d]) n_pass++;
                    else $display("FAIL %s dut%0d rd0: got %h want %h (ra0=%0d)",
                                  x.name, d, rd0_w[d], x.e[2*d], ra0);
                    n_checks++;
                    if (rd1_w[d] === x.e[2*d+1]) n_pass++;
                    else $display("FAIL %s dut%0d rd1: got %h want %h (ra1=%0d)",
                                  x.name, d, rd1_w[d], x.e[2*d+1], ra1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        ra0 = 5'd3;
        #1 push_exp("reset_hold");
        #6 reset_n = 1'b1;

        // Asynchronous clear between edges.
        cycle(1'b1, 5'd3, 64'hDEAD_BEEF_0000_0001, 5'd3, 5'd3, "wr3");
        cycle(1'b0, 5'd0, 64'h0, 5'd3, 5'd3, "rd3");
        reset_pulse("clr_low");
        cycle(1'b0, 5'd0, 64'h0, 5'd3, 5'd3, "rd3_after_clr");
        cycle(1'b1, 5'd3, 64'h5, 5'd3, 5'd3, "wr3_5");
        cycle(1'b0, 5'd0, 64'h0, 5'd3, 5'd3, "rd3_5");

        // Fill and sweep both ports in opposite directions.
        for (int k = 0; k < 31; k++) begin
            cycle(1'b1, 5'(k), 64'h1000 + 64'(k), 5'(k), 5'd0, "fill");
        end
        for (int a = 0; a < 32; a++) begin
            cycle(1'b0, 5'd0, 64'h0, 5'(a), 5'(31 - a), "sweep");
        end

        // Zero register write attempt.
        cycle(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, "zero_wr");
        cycle(1'b0, 5'd0, 64'h0, 5'd31, 5'd31, "zero_rd");
        cycle(1'b0, 5'd0, 64'h0, 5'd31, 5'd31, "zero_rd2");

        // Forwarding on both ports to the write target.
        cycle(1'b1, 5'd7, 64'hA, 5'd7, 5'd7, "byp_a");
        cycle(1'b1, 5'd7, 64'hB, 5'd7, 5'd7, "byp_b");
        cycle(1'b0, 5'd0, 64'h0, 5'd7, 5'd7, "byp_after");

        // Out-of-range write for the shallow variant.
        cycle(1'b1, 5'd25, 64'h77, 5'd25, 5'd25, "oor_wr");
        for (int a = 0; a < 20; a++) begin
            cycle(1'b0, 5'd0, 64'h0, 5'(a), 5'd25, "oor_sweep");
        end

        // Random regression with occasional clears.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), "rand");
            if ($urandom_range(0, 199) == 0) reset_pulse("rand_rst");
        end

        #20;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised register file with two read ports and one write port. Each read port is a generalised DEPTH:1, WIDTH-bit selector over internal storage.
- Replaces the discrete per-register storage plus wide-mux arrangement in the datapath decode stage.
- Adds over the fixed selector:
  - clocked write
  - asynchronous clear
  - hardwired zero register
  - write-to-read bypass
  - out-of-range address handling

Parameters:
- WIDTH, 64, data width of every register and port.
- DEPTH, 32, number of registers; legal range 2..256, not required to be a power of two.
- AW, 5, address width; must satisfy 2**AW >= DEPTH.
- ZERO_EN, 1, 1 = register ZERO_IDX always reads 0 and ignores writes; 0 = ordinary register.
- ZERO_IDX, 31, index of the hardwired-zero register (LEGv8 XZR); must be < DEPTH.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = reads return pre-edge stored value.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable, sampled at rising clk.
- wa  in  AW  write address.
- wd  in  WIDTH  write data.
- ra0  in  AW  read address, port 0.
- ra1  in  AW  read address, port 1.
- rd0  out  WIDTH  read data, port 0 (combinational from ra0/storage/bypass).
- rd1  out  WIDTH  read data, port 1 (same rules as rd0).

Behaviour:
- Storage: DEPTH registers of WIDTH bits.
- Reset:
  - reset_n low clears all registers to 0 immediately, without waiting for clk.
  - While reset_n is low, rd0 = rd1 = 0, bypass is suppressed and writes are blocked.
  - Deassertion is synchronised externally. The first write is accepted on the first rising clk with reset_n high.
- Write:
  - On rising clk, if reset_n=1 and we=1 and wa < DEPTH and not (ZERO_EN and wa==ZERO_IDX), then reg[wa] <= wd.
  - Otherwise no register changes.
  - Write latency is 1 cycle: the stored value is visible on a non-bypassed read from the cycle after the edge.
- Write ignore cases: we=1 with wa >= DEPTH, or to the zero register, is silently dropped. No error output.
- Read, each port independently and purely combinational, in priority order:
  1. reset_n=0 -> 0.
  2. ra >= DEPTH -> 0.
  3. ZERO_EN and ra==ZERO_IDX -> 0.
  4. BYPASS and we and wa==ra (and the write would be accepted) -> wd.
  5. Otherwise reg[ra].
- Bypass is combinational from we/wa/wd. Zero-latency forwarding means rd changes in the same cycle wd changes.
- Both ports may address the same register, including the write target. Both must return identical data.
- No simultaneous-write conflict exists (single write port).
- Width rules:
  - Addresses are compared unsigned at full AW width; no truncation to log2(DEPTH).
  - Data is passed unmodified; no sign or zero extension.
- Reset mid-operation: reset_n falling in the same cycle as a pending write means the write is lost. All registers read 0 after reset_n rises.
- ZERO_EN=0: register ZERO_IDX behaves like any other register.
- No X on outputs after reset for any legal address, including out-of-range ones.

Test Plan:
- Reset and clear:
  - Write 64'hDEAD_BEEF_0000_0001 to reg 3, then pulse reset_n low for 3 ns mid-cycle (no clk edge).
  - rd0 (ra0=3) reads 0 during and after reset.
  - The next write to reg 3 of 64'h5 is visible the cycle after the edge.
- Basic write/read:
  - Write reg k = 64'h1000+k for k=0..30, then sweep ra0=0..31 and ra1=31..0.
  - Each rd equals 64'h1000+addr; reg 31 reads 0.
- Zero register:
  - we=1, wa=31, wd=64'hFFFF_FFFF_FFFF_FFFF.
  - rd0 with ra0=31 stays 0 in the same cycle (no bypass) and in all later cycles.
  - Repeat with ZERO_EN=0: bypass returns all-ones, and the stored value persists.
- Bypass:
  - reg 7 = 64'hA; then we=1, wa=7, wd=64'hB, ra0=ra1=7.
  - BYPASS=1: both ports read 64'hB before the edge.
  - BYPASS=0: both read 64'hA before the edge and 64'hB after.
- Out-of-range (DEPTH=20, AW=5):
  - Write 64'h77 to wa=25.
  - No register changes (sweep 0..19 unchanged); ra0=25 reads 0, including during the write cycle.
- Random regression:
  - 10k cycles of random we/wa/wd/ra0/ra1 with occasional reset_n pulses.
  - Compare both ports against a reference array model each cycle.
